// File: rtl/fp_add_arbiter_if.sv
// Signal bundle between fp_add_arbiter, its requesters, the FP adder core and the response consumer.
// Handshake rule for req_* and resp_*: a transfer happens on a rising Clk edge where valid and ready are both 1.
interface fp_add_arbiter_if #(parameter int NUM_REQ = 4);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;

  logic                  add_start;
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic                  add_done;
  logic [31:0]           add_sum;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [31:0]           resp_result;
  logic                  resp_err;

  logic                  busy;
  logic [1:0]            state;

  modport slave (
    input  req_valid, req_a, req_b, add_done, add_sum, resp_ready,
    output req_ready, add_start, add_a, add_b, resp_valid, resp_id, resp_result, resp_err,
           busy, state
  );

  modport master (
    output req_valid, req_a, req_b, add_done, add_sum, resp_ready,
    input  req_ready, add_start, add_a, add_b, resp_valid, resp_id, resp_result, resp_err,
           busy, state
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one FP adder among NUM_REQ requesters, one operation in flight,
// with a watchdog that turns a hung adder into an error response carrying a quiet NaN.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             Clk,
  input  logic             Clear_n,
  fp_add_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] winner;
  logic [IDW:0]   wsum;
  logic [NUM_REQ-1:0] rot;
  logic           any_valid;
  logic [31:0]    a_sel, b_sel;

  logic [31:0]    a_q, b_q, result_q;
  logic [IDW-1:0] id_q;
  logic           err_q;
  logic [WDW-1:0] wd, wd_inc;
  logic           timeout_hit;

  // Rotate so bit 0 is the requester just after last_grant; the lowest set bit then wins.
  always_comb begin
    rot       = NUM_REQ'({bus.req_valid, bus.req_valid} >> (last_grant + IDW'(1)));
    any_valid = |bus.req_valid;
    pick      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pick = IDW'(i);
    end
    wsum = {1'b0, last_grant} + {1'b0, pick} + (IDW+1)'(1);
    if (wsum >= (IDW+1)'(NUM_REQ)) wsum = wsum - (IDW+1)'(NUM_REQ);
    winner = wsum[IDW-1:0];
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        a_sel = bus.req_a[32*i +: 32];
        b_sel = bus.req_b[32*i +: 32];
      end
    end
  end

  assign wd_inc      = wd + WDW'(1);
  assign timeout_hit = (wd_inc == WDW'(TIMEOUT));

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.add_done || timeout_hit) state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      last_grant <= IDW'(NUM_REQ - 1);
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      wd         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            a_q  <= a_sel;
            b_q  <= b_sel;
            id_q <= winner;
          end
        end
        ISSUE: wd <= '0;
        WAIT: begin
          wd <= wd_inc;
          // A result arriving on the timeout cycle still counts as a normal result.
          if (bus.add_done) begin
            result_q <= bus.add_sum;
            err_q    <= 1'b0;
          end else if (timeout_hit) begin
            result_q <= QNAN;
            err_q    <= 1'b1;
          end
        end
        RESP: if (bus.resp_ready) last_grant <= id_q;
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = (state == IDLE && Clear_n && any_valid) ? (NUM_REQ'(1) << winner) : '0;
  assign bus.add_start   = (state == ISSUE);
  assign bus.add_a       = a_q;
  assign bus.add_b       = b_q;
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_id     = id_q;
  assign bus.resp_result = result_q;
  assign bus.resp_err    = err_q;
  assign bus.busy        = (state != IDLE);
  assign bus.state       = state;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: directed scenarios plus a randomized phase, all scored against a
// transaction-level model (round-robin scan, fixed latency formula, expected response queue).
module tb_fp_add_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;
  localparam int IDW = $clog2(NUM_REQ);
  localparam int W = 1 + 32 + IDW;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic Clk, Clear_n;
  fp_add_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
  fp_add_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (.Clk(Clk), .Clear_n(Clear_n), .bus(bus));

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int mode = 0;
  int k_cfg = 3;
  bit stray_done = 0;

  // model state
  logic [W-1:0] exp_q[$];
  bit in_flight = 0;
  int model_last = NUM_REQ - 1;
  int grant_cyc, keff, k_cur, w;
  logic [31:0] exp_a, exp_b;
  logic [NUM_REQ-1:0] grant_seen = '0;
  logic [NUM_REQ-1:0] exp_ready;

  // observations of the DUT
  int dut_grant_log[$];
  int dut_grant_cyc, dut_start_cyc, dut_rise_cyc, hs_cyc;
  int dut_grant_count = 0, dut_start_count = 0, hs_count = 0;
  bit rise_seen = 0;
  logic [W-1:0] dut_resp;

  // adder model
  bit pend = 0;
  int remain;
  logic [31:0] pend_sum;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stand-in for the FP core: the arbiter only forwards add_sum, so any deterministic function
  // of the operands works; the one IEEE case used by the directed test is tabled.
  function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a + b;
  endfunction

  function automatic int model_winner(input logic [NUM_REQ-1:0] v, input int last);
    for (int s = 1; s <= NUM_REQ; s++) begin
      int idx;
      idx = (last + s) % NUM_REQ;
      if ((v & (NUM_REQ'(1) << idx)) != '0) return idx;
    end
    return -1;
  endfunction

  function automatic int ready_index(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if ((v & (NUM_REQ'(1) << i)) != '0) return i;
    return -1;
  endfunction

  // clock / reset
  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end
  initial forever begin
    @(posedge Clk);
    cyc++;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic req(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i] = 1'b1;
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    tick();
    Clear_n = 0;
    tick();
    tick();
    Clear_n = 1;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_count < target && n < budget) begin
      tick();
      n++;
    end
    check("handshake_in_time", hs_count >= target, 1);
  endtask

  task automatic wait_grant(input int target, input int budget);
    int n = 0;
    while (dut_grant_count < target && n < budget) begin
      tick();
      n++;
    end
    check("grant_in_time", dut_grant_count >= target, 1);
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while (in_flight && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_time", in_flight, 0);
  endtask

  // requester driver: mode 0 = directed, 1 = random, 2 = every requester always valid
  initial forever begin
    @(posedge Clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mode == 2) begin
        if (grant_seen[i] || !bus.req_valid[i]) req(i, $urandom, $urandom);
      end else if (mode == 1) begin
        if (grant_seen[i]) bus.req_valid[i] = 1'b0;
        else if (!bus.req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) req(i, $urandom, $urandom);
        end else if ($urandom_range(0, 19) == 0) bus.req_valid[i] = 1'b0;
      end else if (grant_seen[i]) bus.req_valid[i] = 1'b0;
    end
    grant_seen = '0;
    if (mode == 1) begin
      bus.resp_ready = ($urandom_range(0, 2) != 0);
      k_cfg = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TIMEOUT + 2);
    end
  end

  // adder model: done pulse k cycles after add_start (k = 0 means it never answers)
  initial begin
    bus.add_done = 1'b0;
    bus.add_sum  = '0;
    forever begin
      @(posedge Clk);
      #1;
      bus.add_done = 1'b0;
      if (stray_done) begin
        bus.add_done = 1'b1;
        bus.add_sum  = 32'hDEAD_BEEF;
        stray_done   = 0;
      end else if (pend && Clear_n) begin
        remain--;
        if (remain == 0) begin
          bus.add_done = 1'b1;
          bus.add_sum  = pend_sum;
          pend = 0;
        end
      end
    end
  end

  // monitor + scoreboard
  initial forever begin
    @(negedge Clk);
    if (!Clear_n) begin
      exp_q.delete();
      in_flight  = 0;
      model_last = NUM_REQ - 1;
      pend       = 0;
      rise_seen  = 0;
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_ctrl", {bus.busy, bus.resp_valid, bus.add_start}, 0);
      check("rst_resp", {bus.resp_err, bus.resp_result, bus.resp_id}, 0);
      check("rst_ops", {bus.add_a, bus.add_b}, 0);
    end else begin
      if (bus.req_ready != '0) begin
        dut_grant_cyc = cyc;
        dut_grant_count++;
        dut_grant_log.push_back(ready_index(bus.req_ready));
      end
      if (bus.add_start) begin
        dut_start_cyc = cyc;
        dut_start_count++;
      end
      if (bus.resp_valid && !rise_seen) begin
        dut_rise_cyc = cyc;
        rise_seen = 1;
      end
      if (bus.resp_valid && bus.resp_ready) begin
        dut_resp = {bus.resp_err, bus.resp_result, bus.resp_id};
        hs_cyc = cyc;
        hs_count++;
        rise_seen = 0;
      end

      check("busy", bus.busy, in_flight);
      if (!in_flight) begin
        w = model_winner(bus.req_valid, model_last);
        exp_ready = (w < 0) ? '0 : (NUM_REQ'(1) << w);
        check("req_ready", bus.req_ready, exp_ready);
        check("idle_quiet", {bus.add_start, bus.resp_valid}, 0);
        if (w >= 0) begin
          grant_seen = grant_seen | exp_ready;
          k_cur = k_cfg;
          keff  = (k_cur >= 1 && k_cur <= TIMEOUT) ? k_cur : TIMEOUT;
          exp_a = bus.req_a[32*w +: 32];
          exp_b = bus.req_b[32*w +: 32];
          if (k_cur >= 1 && k_cur <= TIMEOUT) exp_q.push_back({1'b0, ref_sum(exp_a, exp_b), IDW'(w)});
          else exp_q.push_back({1'b1, QNAN, IDW'(w)});
          grant_cyc = cyc;
          in_flight = 1;
        end
      end else begin
        check("req_ready_busy", bus.req_ready, 0);
        check("add_start", bus.add_start, cyc == grant_cyc + 1);
        if (bus.add_start) begin
          check("add_a", bus.add_a, exp_a);
          check("add_b", bus.add_b, exp_b);
          if (k_cur > 0) begin
            pend     = 1;
            remain   = k_cur;
            pend_sum = ref_sum(bus.add_a, bus.add_b);
          end
        end
        check("resp_valid", bus.resp_valid, cyc >= grant_cyc + keff + 2);
        if (bus.resp_valid) begin
          check("resp_word", {bus.resp_err, bus.resp_result, bus.resp_id}, exp_q[0]);
          if (bus.resp_ready) begin
            model_last = int'(exp_q[0][IDW-1:0]);
            void'(exp_q.pop_front());
            in_flight = 0;
          end
        end
      end
    end
  end

  // main sequence
  initial begin
    int base, gbase, scount;
    int exp_order[5];
    logic [31:0] a6, b6;
    exp_order = '{0, 1, 2, 3, 0};
    Clear_n = 0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #2 Clear_n = 1;

    // single request, k = 3
    tick();
    k_cfg = 3;
    req(0, 32'h3F80_0000, 32'h4000_0000);
    wait_hs(hs_count + 1, 60);
    check("t1_start_lat", dut_start_cyc - dut_grant_cyc, 1);
    check("t1_resp_lat", dut_rise_cyc - dut_grant_cyc, 5);
    check("t1_resp", dut_resp, {1'b0, 32'h4040_0000, IDW'(0)});

    // all requesters valid continuously after reset
    do_reset();
    k_cfg = 2;
    base = dut_grant_log.size();
    mode = 2;
    wait_hs(hs_count + 5, 120);
    mode = 0;
    tick();
    bus.req_valid = '0;
    wait_quiet(60);
    for (int i = 0; i < 5; i++)
      check("t2_order", (dut_grant_log.size() > base + i) ? dut_grant_log[base + i] : -1, exp_order[i]);

    // adder never answers, then a normal operation follows
    tick();
    k_cfg = 0;
    req(1, $urandom, $urandom);
    wait_hs(hs_count + 1, 60);
    check("t3_abort", dut_resp, {1'b1, QNAN, IDW'(1)});
    check("t3_abort_lat", dut_rise_cyc - dut_grant_cyc, TIMEOUT + 2);
    k_cfg = 3;
    req(2, $urandom, $urandom);
    wait_hs(hs_count + 1, 60);
    check("t3_next_ok", {dut_resp[W-1], dut_resp[IDW-1:0]}, {1'b0, IDW'(2)});

    // back-pressure on the response channel
    tick();
    bus.resp_ready = 1'b0;
    k_cfg = 2;
    req(0, $urandom, $urandom);
    req(1, $urandom, $urandom);
    begin
      int n = 0;
      while (!bus.resp_valid && n < 40) begin
        tick();
        n++;
      end
    end
    gbase = dut_grant_count;
    scount = dut_start_count;
    repeat (10) tick();
    check("t4_hold_valid", bus.resp_valid, 1);
    check("t4_no_grant", dut_grant_count, gbase);
    check("t4_no_start", dut_start_count, scount);
    bus.resp_ready = 1'b1;
    wait_hs(hs_count + 1, 10);
    wait_grant(gbase + 1, 10);
    check("t4_regrant_lat", dut_grant_cyc - hs_cyc, 1);
    check("t4_regrant_id", dut_grant_log[$], 1);
    wait_hs(hs_count + 1, 60);

    // reset in WAIT, stray done afterwards, round-robin pointer restarts
    tick();
    k_cfg = 0;
    req(2, $urandom, $urandom);
    wait_grant(dut_grant_count + 1, 20);
    repeat (4) tick();
    Clear_n = 0;
    #1;
    check("t5_clear_ctrl", {bus.req_ready, bus.add_start, bus.resp_valid, bus.busy}, 0);
    check("t5_clear_data", {bus.resp_err, bus.resp_id, bus.resp_result}, 0);
    bus.req_valid = '0;
    tick();
    tick();
    Clear_n = 1;
    stray_done = 1;
    repeat (3) tick();
    check("t5_stray_ignored", {bus.busy, bus.resp_valid}, 0);
    k_cfg = 3;
    gbase = dut_grant_count;
    req(3, $urandom, $urandom);
    req(0, $urandom, $urandom);
    wait_grant(gbase + 1, 10);
    check("t5_first_grant", dut_grant_log[$], 0);
    wait_hs(hs_count + 2, 80);

    // done on the same cycle the watchdog expires
    tick();
    k_cfg = TIMEOUT;
    a6 = $urandom;
    b6 = $urandom;
    req(1, a6, b6);
    wait_hs(hs_count + 1, 60);
    check("t6_done_wins", dut_resp, {1'b0, ref_sum(a6, b6), IDW'(1)});
    check("t6_lat", dut_rise_cyc - dut_grant_cyc, TIMEOUT + 2);

    // randomized traffic
    mode = 1;
    repeat (800) tick();
    mode = 0;
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    wait_quiet(100);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
